// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter_sched timer scheduler: state encodings
// and default sizing constants.
package counter_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational one-hot winner pick: round-robin from ptr by default, or a
// lowest-index-wins encoder when COUNTER_SCHED_FIXED_PRIO_EN is defined.
module counter_sched_rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  // One extra bit lets ptr+i reach 2*NUM_REQ-2 before the modulo fold.
  localparam int IW = PW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'(ptr) + IW'(i);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/counter_sched.sv
// Shared down-counting timer arbitrated among NUM_REQ requesters.
// Define COUNTER_SCHED_FIXED_PRIO_EN for fixed-priority instead of round-robin.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] load_val,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_ptr;
  logic               active;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  counter_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req (req),
    .ptr (arb_ptr),
    .gnt (arb_gnt)
  );

  assign active = |(req & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    count_d = count_q;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          gnt_d   = arb_gnt;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              count_d = load_val[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      RUN: begin
        // A dropped request wins over completion; both end the run without wrap.
        if (!active || (count_q == '0)) begin
          state_d = IDLE;
          gnt_d   = '0;
          count_d = '0;
          if (active) begin
            done_d = gnt_q;
          end
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
              ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
          end
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      count_q <= '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign count = count_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed testbench for counter_sched: vector table for the basic sequences,
// hand-written sequences for round-robin, abort, reset and max-load cases.
module tb_counter_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_sched #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .load_val (load_val),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  typedef struct {
    string          name;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N*W-1:0] load;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [N*W-1:0] ld(input int ch, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[ch*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] ld_all(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic rs, input logic [N-1:0] r,
                              input logic [N*W-1:0] l, input logic [N-1:0] g,
                              input logic [N-1:0] d, input logic b, input logic [W-1:0] c);
    vec_t v;
    v.name = nm; v.rstn = rs; v.req = r; v.load = l;
    v.gnt = g; v.done = d; v.busy = b; v.count = c;
    return v;
  endfunction

  task automatic applyStimulus(input logic rs, input logic [N-1:0] r, input logic [N*W-1:0] l);
    resetn   = rs;
    req      = r;
    load_val = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ed,
                             input logic eb, input logic [W-1:0] ec);
    total++;
    if (gnt !== eg) begin
      bad++;
      $display("[TB] FAIL %s gnt: got %b want %b", nm, gnt, eg);
    end
    total++;
    if (done !== ed) begin
      bad++;
      $display("[TB] FAIL %s done: got %b want %b", nm, done, ed);
    end
    total++;
    if (busy !== eb) begin
      bad++;
      $display("[TB] FAIL %s busy: got %b want %b", nm, busy, eb);
    end
    total++;
    if (count !== ec) begin
      bad++;
      $display("[TB] FAIL %s count: got %h want %h", nm, count, ec);
    end
  endtask

  function automatic logic [N-1:0] oh(input int ch);
    logic [N-1:0] r;
    r = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  initial begin
    resetn   = 1'b0;
    req      = '0;
    load_val = '0;

    vecs[0]  = mk("reset",     1'b0, 4'b0000, '0,        4'b0000, 4'b0000, 1'b0, 32'd0);
    vecs[1]  = mk("idle",      1'b1, 4'b0000, '0,        4'b0000, 4'b0000, 1'b0, 32'd0);
    vecs[2]  = mk("grant5",    1'b1, 4'b0001, ld(0, 5),  4'b0001, 4'b0000, 1'b1, 32'd5);
    for (int k = 0; k < 5; k++)
      vecs[3+k] = mk("count5", 1'b1, 4'b0001, ld(0, 5),  4'b0001, 4'b0000, 1'b1, 32'(4 - k));
    vecs[8]  = mk("done5",     1'b1, 4'b0001, ld(0, 5),  4'b0000, 4'b0001, 1'b0, 32'd0);
    vecs[9]  = mk("idle2",     1'b1, 4'b0000, '0,        4'b0000, 4'b0000, 1'b0, 32'd0);
    vecs[10] = mk("grant0",    1'b1, 4'b0100, ld(2, 0),  4'b0100, 4'b0000, 1'b1, 32'd0);
    vecs[11] = mk("done0",     1'b1, 4'b0100, ld(2, 0),  4'b0000, 4'b0100, 1'b0, 32'd0);
    vecs[12] = mk("idle3",     1'b1, 4'b0000, '0,        4'b0000, 4'b0000, 1'b0, 32'd0);
    vecs[13] = mk("reset2",    1'b0, 4'b0000, '0,        4'b0000, 4'b0000, 1'b0, 32'd0);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].rstn, vecs[v].req, vecs[v].load);
      checkOutput(vecs[v].name, vecs[v].gnt, vecs[v].done, vecs[v].busy, vecs[v].count);
    end

    // All channels requesting with load 3: each grant runs 5 edges including done.
    for (int g = 0; g < 5; g++) begin
      int ch;
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
      ch = 0;
`else
      ch = g % N;
`endif
      applyStimulus(1'b1, 4'b1111, ld_all(3));
      checkOutput("rr_grant", oh(ch), 4'b0000, 1'b1, 32'd3);
      for (int k = 2; k >= 0; k--) begin
        applyStimulus(1'b1, 4'b1111, ld_all(3));
        checkOutput("rr_count", oh(ch), 4'b0000, 1'b1, 32'(k));
      end
      applyStimulus(1'b1, 4'b1111, ld_all(3));
      checkOutput("rr_done", 4'b0000, oh(ch), 1'b0, 32'd0);
    end

    applyStimulus(1'b1, 4'b0010, ld(1, 10));
    checkOutput("abort_grant", 4'b0010, 4'b0000, 1'b1, 32'd10);
    for (int k = 9; k >= 6; k--) begin
      applyStimulus(1'b1, 4'b0110, ld(1, 10) | ld(2, 2));
      checkOutput("abort_count", 4'b0010, 4'b0000, 1'b1, 32'(k));
    end
    applyStimulus(1'b1, 4'b0100, ld(1, 10) | ld(2, 2));
    checkOutput("abort", 4'b0000, 4'b0000, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0100, ld(1, 10) | ld(2, 2));
    checkOutput("pending_grant", 4'b0100, 4'b0000, 1'b1, 32'd2);
    applyStimulus(1'b1, 4'b0100, ld(2, 2));
    checkOutput("pending_count", 4'b0100, 4'b0000, 1'b1, 32'd1);
    applyStimulus(1'b1, 4'b0100, ld(2, 2));
    checkOutput("pending_count", 4'b0100, 4'b0000, 1'b1, 32'd0);
    applyStimulus(1'b1, 4'b0100, ld(2, 2));
    checkOutput("pending_done", 4'b0000, 4'b0100, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b0000, '0);
    checkOutput("idle4", 4'b0000, 4'b0000, 1'b0, 32'd0);

    applyStimulus(1'b1, 4'b0010, ld(1, 7));
    checkOutput("run7", 4'b0010, 4'b0000, 1'b1, 32'd7);
    applyStimulus(1'b0, 4'b0010, ld(1, 7));
    checkOutput("mid_reset", 4'b0000, 4'b0000, 1'b0, 32'd0);
    applyStimulus(1'b1, 4'b1111, ld_all(1));
    checkOutput("ptr_after_reset", 4'b0001, 4'b0000, 1'b1, 32'd1);
    applyStimulus(1'b1, 4'b0000, '0);
    checkOutput("abort2", 4'b0000, 4'b0000, 1'b0, 32'd0);

    // Load value changes after the grant must not disturb the running count.
    applyStimulus(1'b1, 4'b1000, ld(3, 32'hFFFF_FFFF));
    checkOutput("max_grant", 4'b1000, 4'b0000, 1'b1, 32'hFFFF_FFFF);
    for (int k = 1; k <= 100; k++) begin
      applyStimulus(1'b1, 4'b1000, ld(3, 5));
      checkOutput("max_count", 4'b1000, 4'b0000, 1'b1, 32'hFFFF_FFFF - 32'(k));
    end
    applyStimulus(1'b1, 4'b0000, ld(3, 5));
    checkOutput("max_abort", 4'b0000, 4'b0000, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
